// File: rtl/round_engine.sv
// round_engine: iterative 128-bit block-cipher core, one round per clock.
// SubBytes/ShiftRows (substitutekey), MixColumns (diffusion) and
// addroundkey are wrapped in an FSM with a round counter and valid/ready
// handshakes on both sides. Round keys come from an external schedule
// addressed by rk_idx and must be valid combinationally in the same cycle.
// Optional macro ROUND_ENGINE_HANDOFF_EN: in DONE the engine accepts the
// next block on the same cycle as the output handshake, skipping IDLE.
module round_engine #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic [CNT_W-1:0] rk_idx,
    input  logic [127:0]     rk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam state_t           FIRST_ST = (NUM_ROUNDS > 1) ? ROUND : FINAL;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] FIN_IDX  = CNT_W'(NUM_ROUNDS);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [127:0]     state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;
    logic             deliver;

    // Byte k sits at [127-8k -: 8] and maps to row k%4, column k/4.
    // Substitution followed by a left rotation of row r by r columns.
    function automatic logic [127:0] substitutekey(input logic [127:0] s);
        logic [127:0] r;
        int unsigned  src;
        r = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            src = (k % 4) + 4 * (((k / 4) + (k % 4)) % 4);
            r[127 - 8*k -: 8] = SBOX[s[127 - 8*src -: 8]];
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column mix over GF(2^8) with the fixed {02,03,01,01} circulant.
    function automatic logic [127:0] diffusion(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        return r;
    endfunction

    function automatic logic [127:0] addroundkey(input logic [127:0] s,
                                                 input logic [127:0] k);
        return s ^ k;
    endfunction

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid_q && out_ready;

    // Control FSM, round counter and the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            cnt         <= '0;
            state_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        state_q    <= addroundkey(in_data, rk);
                        cnt        <= CNT_W'(1);
                        in_ready_q <= 1'b0;
                        st         <= FIRST_ST;
                    end
                end
                ROUND: begin
                    state_q <= addroundkey(diffusion(substitutekey(state_q)), rk);
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        st <= FINAL;
                    end
                end
                FINAL: begin
                    state_q     <= addroundkey(substitutekey(state_q), rk);
                    out_valid_q <= 1'b1;
                    st          <= DONE;
                end
                DONE: begin
                    if (deliver) begin
                        out_valid_q <= 1'b0;
`ifdef ROUND_ENGINE_HANDOFF_EN
                        // in_ready mirrors out_ready here, so in_valid alone
                        // means a simultaneous input handshake (rk_idx is 0).
                        if (in_valid) begin
                            state_q <= addroundkey(in_data, rk);
                            cnt     <= CNT_W'(1);
                            st      <= FIRST_ST;
                        end else begin
                            in_ready_q <= 1'b1;
                            st         <= IDLE;
                        end
`else
                        in_ready_q <= 1'b1;
                        st         <= IDLE;
`endif
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // Round-key index requested from the key schedule this cycle.
    always_comb begin
        rk_idx = '0;
        case (st)
            ROUND:   rk_idx = cnt;
            FINAL:   rk_idx = FIN_IDX;
            default: rk_idx = '0;
        endcase
    end

`ifdef ROUND_ENGINE_HANDOFF_EN
    assign in_ready = (st == DONE) ? out_ready : in_ready_q;
`else
    assign in_ready = in_ready_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = state_q;
    assign busy      = (st != IDLE);

endmodule

// File: doc/round_engine.md
Name: round_engine

Overview:
- Iterative multi-round block-cipher core: one round per clock on a 128-bit state, NUM_ROUNDS rounds per block.
- Reuses the existing combinational substitutekey, diffusion and addroundkey datapath, wrapped in an FSM, a round counter and valid/ready handshakes on input and output.
- Sits between the block-input buffer and the output formatter.
- Round keys are supplied by the external key schedule, indexed by rk_idx.

Parameters:
- NUM_ROUNDS, 10, full rounds per block (>=1); the last round omits diffusion.
- CNT_W, $clog2(NUM_ROUNDS+1), width of the round counter and of rk_idx.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_data holds a block
- in_ready  output  1  engine can accept a block
- in_data  input  128  plaintext block; byte k = in_data[127-8k -: 8] maps to state[k%4][k/4]
- rk_idx  output  CNT_W  index of the round key required this cycle
- rk  input  128  round key for rk_idx, valid combinationally in the same cycle, same byte mapping
- out_valid  output  1  out_data holds a finished block
- out_ready  input  1  consumer accepts out_data
- out_data  output  128  ciphertext, same byte mapping
- busy  output  1  high in ROUND, FINAL and DONE

Behaviour:
- Reset values: state IDLE, counter 0, state register 0, out_valid=0, out_data=0, busy=0, in_ready=0 during the reset cycle and 1 from the following cycle.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid&&in_ready: state <= in_data ^ rk, counter <= 1.
  - Next state is ROUND if NUM_ROUNDS>1, else FINAL.
- ROUND:
  - rk_idx=counter.
  - state <= addroundkey(diffusion(substitutekey(state)), rk), counter <= counter+1.
  - Move to FINAL when counter == NUM_ROUNDS-1.
- FINAL:
  - rk_idx=NUM_ROUNDS.
  - state <= addroundkey(substitutekey(state), rk), with no diffusion.
  - Go to DONE.
- DONE:
  - out_valid=1, out_data=state, both held stable until out_ready.
  - On out_valid&&out_ready: out_valid <= 0 next cycle, go to IDLE.
- rk_idx outside ROUND/FINAL/IDLE is 0.
- Latency: accept at cycle 0 gives out_valid high at cycle NUM_ROUNDS+1. Throughput is one block per NUM_ROUNDS+2 cycles (macro off).
- in_ready=0 in ROUND, FINAL and DONE. in_valid is ignored there and the upstream block is held.
- out_valid only drops after a handshake, never spontaneously.
- Counter width: counter never exceeds NUM_ROUNDS, so there is no wrap.
- rst at any time, including mid-round or in DONE with out_valid=1, returns the block to reset values on the next edge. A partially processed block is discarded with no output.
- The state register updates only in IDLE-accept, ROUND and FINAL.

Optional Feature:
- Macro: ROUND_ENGINE_HANDOFF_EN.
- When defined:
  - In DONE, in_ready = out_ready.
  - A simultaneous output handshake and input handshake loads the new block (in_data ^ rk with rk_idx=0) and goes directly to ROUND/FINAL, skipping IDLE.
  - rk_idx=0 in DONE.
  - out_valid drops the next cycle.
  - Sustained throughput becomes one block per NUM_ROUNDS+1 cycles.
- When undefined: in_ready=0 in DONE; behaviour is as above.

Test Plan:
- FIPS-197 AES-128, NUM_ROUNDS=10:
  - Stimulus: in_data=00112233445566778899aabbccddeeff, rk from the expanded key 000102030405060708090a0b0c0d0e0f, out_ready=1.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rises exactly 11 cycles after accept.
  - Required: rk_idx sequence 0,1,…,10 on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - Required: out_data and out_valid stable.
  - Required: in_ready=0 and a second in_valid block is not accepted until the cycle after the out handshake.
- Reset mid-operation: assert rst for 1 cycle while counter=4.
  - Required: the next cycle shows out_valid=0, busy=0, out_data=0.
  - Required: in_ready=1 the cycle after that; a new block then produces the correct ciphertext.
- NUM_ROUNDS=1 build:
  - Stimulus: in_data=0, rk constant 0.
  - Required: output equals substitutekey of the all-zero state (all bytes 63), out_valid 2 cycles after accept.
- ROUND_ENGINE_HANDOFF_EN defined, two back-to-back FIPS vectors with in_valid and out_ready held high.
  - Required: second block accepted in the same cycle as the first output handshake.
  - Required: outputs 11 cycles apart, both equal to 69c4e0d86a7b0430d8cdb78070b4c55a.
- Macro undefined, same stimulus:
  - Required: outputs 12 cycles apart, no block dropped or duplicated.
